// File: rtl/bus_master4_if.sv
// Request/response handshake bundle between a requester and bus_master4.
// master = requester side, slave = bus_master4 side.
interface bus_master4_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_wr;
   logic [1:0] req_addr;
   logic [3:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/bus_master4.sv
// Shared 4-bit tri-state bus master: write = drive 2 cycles + ld strobe, read = oe 2 cycles then held response.
// One transfer in flight; req_ready only in IDLE, response held until rsp_ready, TURN idle cycles after each transfer.
module bus_master4 #(
   parameter int TURN = 1
) (
   input  logic             clk,
   input  logic             rst,
   bus_master4_if.slave     bus,
   inout  wire  [3:0]       data,
   output logic [3:0]       ld,
   output logic [3:0]       oe,
   output logic [7:0]       wr_count,
   output logic [7:0]       rd_count
);

   typedef enum logic [2:0] {
      IDLE, WDRIVE, WLOAD, RSEL, RSAMPLE, RESP, TURNA
   } state_t;

   state_t     state;
   logic [1:0] addr_l;
   logic [3:0] wdata_l;
   logic       drive;
   logic [1:0] tcnt;

   assign data = drive ? wdata_l : 4'bz;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         addr_l        <= 2'd0;
         wdata_l       <= 4'd0;
         drive         <= 1'b0;
         tcnt          <= 2'd0;
         ld            <= 4'd0;
         oe            <= 4'd0;
         wr_count      <= 8'd0;
         rd_count      <= 8'd0;
         bus.req_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 4'd0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid && bus.req_ready) begin
                  addr_l        <= bus.req_addr;
                  wdata_l       <= bus.req_wdata;
                  bus.req_ready <= 1'b0;
                  if (bus.req_wr) begin
                     state <= WDRIVE;
                     drive <= 1'b1;
                  end else begin
                     state <= RSEL;
                     oe    <= 4'b0001 << bus.req_addr;
                  end
               end
            end
            WDRIVE: begin
               state <= WLOAD;
               ld    <= 4'b0001 << addr_l;
            end
            WLOAD: begin
               ld       <= 4'd0;
               drive    <= 1'b0;
               wr_count <= wr_count + 8'd1;
               if (TURN == 0) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
               end else begin
                  state <= TURNA;
                  tcnt  <= 2'(TURN - 1);
               end
            end
            RSEL: begin
               state <= RSAMPLE;
            end
            RSAMPLE: begin
               // Target is still enabled up to this edge, so data is valid here.
               bus.rsp_rdata <= data;
               bus.rsp_valid <= 1'b1;
               oe            <= 4'd0;
               state         <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  rd_count      <= rd_count + 8'd1;
                  if (TURN == 0) begin
                     state         <= IDLE;
                     bus.req_ready <= 1'b1;
                  end else begin
                     state <= TURNA;
                     tcnt  <= 2'(TURN - 1);
                  end
               end
            end
            TURNA: begin
               if (tcnt == 2'd0) begin
                  state         <= IDLE;
                  bus.req_ready <= 1'b1;
               end else begin
                  tcnt <= tcnt - 2'd1;
               end
            end
            default: begin
               state         <= IDLE;
               drive         <= 1'b0;
               ld            <= 4'd0;
               oe            <= 4'd0;
               bus.req_ready <= 1'b1;
               bus.rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_master4.sv
// Bench for bus_master4: target register model on the shared bus plus a read-response scoreboard.
module tb_bus_master4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bus_master4_if bif ();
   bus_master4_if bif0 ();
   wire  [3:0] data;
   wire  [3:0] data0;
   logic [3:0] ld, oe, ld0, oe0;
   logic [7:0] wr_count, rd_count, wr0, rd0;

   bus_master4 #(.TURN(1)) dut (
      .clk(clk), .rst(rst), .bus(bif.slave), .data(data),
      .ld(ld), .oe(oe), .wr_count(wr_count), .rd_count(rd_count)
   );

   bus_master4 #(.TURN(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bif0.slave), .data(data0),
      .ld(ld0), .oe(oe0), .wr_count(wr0), .rd_count(rd0)
   );

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   // Target registers on the shared bus.
   logic [3:0] regs [4] = '{default: 4'd0};
   logic [3:0] model [4] = '{default: 4'd0};
   logic       tgt_en;
   logic [3:0] tgt_val;
   always_comb begin
      tgt_en  = (oe != 4'd0);
      tgt_val = 4'd0;
      for (int i = 0; i < 4; i++) if (oe[i]) tgt_val = regs[i];
   end
   assign data = tgt_en ? tgt_val : 4'bz;

   always @(posedge clk) begin
      for (int i = 0; i < 4; i++) if (ld[i]) regs[i] <= data;
   end

   logic [3:0] exp_q [$];
   int drv_cycles = 0, oe_cycles = 0, ld_cycles = 0, viol = 0;
   int last_drive_cyc = -1, last_oe_cyc = -1, w2r_gap = -1;
   int last_acc = 0, prev_acc = 0, acc0 = 0, prev_acc0 = 0;
   logic [3:0] last_ld = 4'd0, last_oe = 4'd0;

   always @(posedge clk) begin
      if (!rst) begin
         if (dut.drive) begin
            drv_cycles++;
            last_drive_cyc = cyc;
         end
         if (oe != 4'd0) begin
            oe_cycles++;
            last_oe = oe;
            if (last_drive_cyc > last_oe_cyc && last_drive_cyc >= 0)
               w2r_gap = cyc - last_drive_cyc - 1;
            last_oe_cyc = cyc;
         end
         if (ld != 4'd0) begin
            ld_cycles++;
            last_ld = ld;
         end
         if ((dut.drive && oe != 4'd0) || $countones(ld) > 1 || $countones(oe) > 1 ||
             (ld != 4'd0 && oe != 4'd0))
            viol++;
         if (bif.rsp_valid && bif.rsp_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL rsp_unexpected: got %h, none expected", bif.rsp_rdata);
            end else begin
               logic [3:0] e;
               e = exp_q.pop_front();
               if (bif.rsp_rdata !== e) begin
                  fails++;
                  $display("FAIL rsp_rdata: got %h, expected %h", bif.rsp_rdata, e);
               end
            end
         end
         if (bif.req_valid && bif.req_ready) begin
            prev_acc = last_acc;
            last_acc = cyc;
         end
         if (bif0.req_valid && bif0.req_ready) begin
            prev_acc0 = acc0;
            acc0 = cyc;
         end
      end
      cyc <= cyc + 1;
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic wr, input logic [1:0] a, input logic [3:0] d, input bit keep);
      int n;
      n = 0;
      bif.req_valid = 1'b1;
      bif.req_wr    = wr;
      bif.req_addr  = a;
      bif.req_wdata = d;
      while (!bif.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= 50) begin
         fails++;
         $display("FAIL send_timeout: req_ready=%b after %0d cycles, expected 1", bif.req_ready, n);
      end else if (wr) begin
         model[a] = d;
      end else begin
         exp_q.push_back(model[a]);
      end
      @(negedge clk);
      if (!keep) bif.req_valid = 1'b0;
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bif.req_ready) && n < bound) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (n >= bound) begin
         fails++;
         $display("FAIL drain_timeout: %0d responses pending, req_ready=%b", exp_q.size(), bif.req_ready);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      tests++; if (bif.req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready: got %b, expected 1", bif.req_ready); end
      tests++; if (bif.rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid: got %b, expected 0", bif.rsp_valid); end
      tests++; if (bif.rsp_rdata !== 4'd0) begin fails++; $display("FAIL rst_rsp_rdata: got %h, expected 0", bif.rsp_rdata); end
      tests++; if (ld !== 4'd0 || oe !== 4'd0) begin fails++; $display("FAIL rst_ld_oe: got ld=%b oe=%b, expected 0", ld, oe); end
      tests++; if (dut.drive !== 1'b0) begin fails++; $display("FAIL rst_drive: got %b, expected 0", dut.drive); end
      tests++; if (wr_count !== 8'd0 || rd_count !== 8'd0) begin fails++; $display("FAIL rst_counts: got wr=%0d rd=%0d, expected 0", wr_count, rd_count); end
   endtask

   task automatic test_write();
      int n;
      drv_cycles = 0; ld_cycles = 0;
      send(1'b1, 2'd2, 4'hA, 1'b0);
      n = 0;
      while (!bif.req_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      tests++; if (n !== 3) begin fails++; $display("FAIL wr_busy_cycles: got %0d, expected 3", n); end
      repeat (2) @(negedge clk);
      tests++; if (drv_cycles !== 2) begin fails++; $display("FAIL wr_drive_cycles: got %0d, expected 2", drv_cycles); end
      tests++; if (ld_cycles !== 1 || last_ld !== 4'b0100) begin fails++; $display("FAIL wr_ld: got %0d cycles ld=%b, expected 1 cycle 0100", ld_cycles, last_ld); end
      tests++; if (regs[2] !== 4'hA) begin fails++; $display("FAIL wr_reg2: got %h, expected a", regs[2]); end
      tests++; if (wr_count !== 8'd1) begin fails++; $display("FAIL wr_count: got %0d, expected 1", wr_count); end
   endtask

   task automatic test_read();
      int n;
      send(1'b1, 2'd1, 4'h5, 1'b0);
      drain(20);
      drv_cycles = 0; oe_cycles = 0;
      bif.rsp_ready = 1'b0;
      send(1'b0, 2'd1, 4'h0, 1'b0);
      n = 0;
      while (!bif.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (bif.rsp_valid !== 1'b1 || bif.rsp_rdata !== 4'h5 || rd_count !== 8'd0) begin
            fails++;
            $display("FAIL rd_hold: got valid=%b rdata=%h rd_count=%0d, expected 1/5/0", bif.rsp_valid, bif.rsp_rdata, rd_count);
         end
         @(negedge clk);
      end
      bif.rsp_ready = 1'b1;
      drain(20);
      tests++; if (rd_count !== 8'd1) begin fails++; $display("FAIL rd_count: got %0d, expected 1", rd_count); end
      tests++; if (oe_cycles !== 2 || last_oe !== 4'b0010) begin fails++; $display("FAIL rd_oe: got %0d cycles oe=%b, expected 2 cycles 0010", oe_cycles, last_oe); end
      tests++; if (drv_cycles !== 0) begin fails++; $display("FAIL rd_master_drive: got %0d cycles, expected 0", drv_cycles); end
      tests++; if (bif.rsp_rdata !== 4'h5) begin fails++; $display("FAIL rd_rdata_hold: got %h, expected 5", bif.rsp_rdata); end
   endtask

   task automatic test_back_to_back();
      w2r_gap = -1;
      send(1'b1, 2'd3, 4'hF, 1'b1);
      send(1'b0, 2'd3, 4'h0, 1'b0);
      drain(30);
      tests++; if (last_acc - prev_acc !== 4) begin fails++; $display("FAIL b2b_accept_gap: got %0d, expected 4", last_acc - prev_acc); end
      tests++; if (w2r_gap < 1) begin fails++; $display("FAIL b2b_turnaround: got %0d idle cycles, expected >= 1", w2r_gap); end
      tests++; if (viol !== 0) begin fails++; $display("FAIL b2b_contention: got %0d, expected 0", viol); end
   endtask

   task automatic test_reset_abort();
      int n;
      logic [3:0] keep0;
      keep0 = model[0];
      ld_cycles = 0;
      send(1'b1, 2'd0, 4'h9, 1'b0);
      model[0] = keep0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++; if (bif.req_ready !== 1'b1 || dut.drive !== 1'b0) begin fails++; $display("FAIL abort_wr_idle: got ready=%b drive=%b, expected 1/0", bif.req_ready, dut.drive); end
      repeat (4) @(negedge clk);
      tests++; if (ld_cycles !== 0 || regs[0] !== keep0) begin fails++; $display("FAIL abort_wr_ld: got %0d ld cycles reg0=%h, expected 0/%h", ld_cycles, regs[0], keep0); end
      tests++; if (wr_count !== 8'd0 || rd_count !== 8'd0) begin fails++; $display("FAIL abort_counts: got wr=%0d rd=%0d, expected 0", wr_count, rd_count); end
      bif.rsp_ready = 1'b0;
      send(1'b0, 2'd3, 4'h0, 1'b0);
      n = 0;
      while (!bif.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      bif.rsp_ready = 1'b1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      tests++; if (bif.rsp_valid !== 1'b0 || bif.rsp_rdata !== 4'd0) begin fails++; $display("FAIL abort_rd_rsp: got valid=%b rdata=%h, expected 0/0", bif.rsp_valid, bif.rsp_rdata); end
      repeat (4) @(negedge clk);
      tests++; if (bif.rsp_valid !== 1'b0 || rd_count !== 8'd0 || bif.req_ready !== 1'b1) begin fails++; $display("FAIL abort_rd_after: got valid=%b rd=%0d ready=%b, expected 0/0/1", bif.rsp_valid, rd_count, bif.req_ready); end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 255; i++) send(1'b1, 2'(i), 4'(i), 1'b0);
      drain(20);
      tests++; if (wr_count !== 8'd255) begin fails++; $display("FAIL wrap_255: got %0d, expected 255", wr_count); end
      send(1'b1, 2'd1, 4'h7, 1'b0);
      drain(20);
      tests++; if (wr_count !== 8'd0) begin fails++; $display("FAIL wrap_0: got %0d, expected 0", wr_count); end
      send(1'b0, 2'd1, 4'h0, 1'b0);
      drain(20);
   endtask

   task automatic test_turn0();
      bif0.req_wr    = 1'b1;
      bif0.req_addr  = 2'd0;
      bif0.req_wdata = 4'h3;
      bif0.req_valid = 1'b1;
      repeat (10) @(negedge clk);
      bif0.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      tests++; if (acc0 - prev_acc0 !== 3) begin fails++; $display("FAIL turn0_accept_gap: got %0d, expected 3", acc0 - prev_acc0); end
      tests++; if (wr0 < 8'd3) begin fails++; $display("FAIL turn0_wr_count: got %0d, expected >= 3", wr0); end
   endtask

   initial begin
      bif.req_valid = 1'b0; bif.req_wr = 1'b0; bif.req_addr = 2'd0; bif.req_wdata = 4'd0;
      bif.rsp_ready = 1'b1;
      bif0.req_valid = 1'b0; bif0.req_wr = 1'b0; bif0.req_addr = 2'd0; bif0.req_wdata = 4'd0;
      bif0.rsp_ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_abort();
      test_wrap();
      test_turn0();
      tests++; if (viol !== 0) begin fails++; $display("FAIL contention_total: got %0d, expected 0", viol); end
      tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL pending_rsp: got %0d, expected 0", exp_q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
